// File: rtl/ir_readout_pkg.sv
// ir_readout_pkg: shared types and constants for the IR sensor readout engine.
package ir_readout_pkg;

  // Largest supported pixel-sync to data delay, in pixel ticks.
  localparam int MAX_SAMPLE_DLY = 7;

  typedef enum logic [2:0] {
    IDLE,
    FSYNC,
    LSYNC,
    PIXELS,
    HBLANK,
    VBLANK
  } state_t;

  // Packet framing carried alongside each pixel through the delay line.
  typedef struct packed {
    logic sop;
    logic eop;
  } marker_t;

  // One delay-line slot: an empty slot has valid = 0.
  typedef struct packed {
    logic    valid;
    marker_t mk;
  } slot_t;

endpackage

// File: rtl/ir_sensor_readout_if.sv
// ir_sensor_readout_if: Avalon-ST pixel stream (source = master, sink = slave).
interface ir_sensor_readout_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;

  modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
  modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/ir_readout_fifo.sv
// ir_readout_fifo: synchronous show-ahead FIFO; head entry is visible while not empty.
// A write to a full FIFO is accepted when a read happens in the same cycle.
module ir_readout_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Force zero on an empty FIFO so the stream outputs never show stale data.
  assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Pointer update for accepted reads and writes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/ir_sensor_readout.sv
// ir_sensor_readout: IR focal-plane readout engine. Generates pixel clock and
// frame/line/pixel syncs, samples datain SAMPLE_DLY ticks after each pixel sync
// and streams one Avalon-ST packet per frame through an output FIFO.
// Optional feature macro: IR_READOUT_TESTPAT_EN adds a `testpat` input that
// replaces datain with a (row + col) test pattern.
module ir_sensor_readout
  import ir_readout_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COLS       = 320,
  parameter int ROWS       = 256,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DLY = 2,
  parameter int FS_LEN     = 4,
  parameter int LS_LEN     = 2,
  parameter int HB_LEN     = 8,
  parameter int VB_LEN     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              cont_mode,
  input  logic              start,
  input  logic [DATA_W-1:0] datain,
`ifdef IR_READOUT_TESTPAT_EN
  input  logic              testpat,
`endif
  output logic              sensor_clk,
  output logic              fsync,
  output logic              lsync,
  output logic              psync,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       frame_cnt,
  ir_sensor_readout_if.master st
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HALF  = CLK_DIV / 2;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       cnt_q, cnt_d, row_q, row_d, last_cnt;
  logic              fsync_q, lsync_q, psync_q, enable_q;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d, frame_cnt_q, frame_cnt_d;
  logic              run, tick, leave_idle, cap, drop, pipe_busy;
  slot_t             push_s, emerge_s;
  logic [DATA_W-1:0] cap_data;
  logic              fifo_full, fifo_empty;
  logic [DATA_W+1:0] fifo_rd;

  // The divider keeps running after IDLE is reached until the delay line drains.
  assign leave_idle = (state_q == IDLE) && enable && (cont_mode || start);
  assign run        = (state_q != IDLE) || pipe_busy;
  assign tick       = run && (div_q == DIV_W'(CLK_DIV - 1));
  assign sensor_clk = run && (div_q < DIV_W'(HALF));
  assign busy       = (state_q != IDLE);

  // Pixel-tick divider; restarts at zero whenever a frame is launched.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (!run || tick || leave_idle) div_d = '0;
  end

  // Tick count for the current state.
  always_comb begin
    case (state_q)
      FSYNC:   last_cnt = 16'(FS_LEN - 1);
      LSYNC:   last_cnt = 16'(LS_LEN - 1);
      PIXELS:  last_cnt = 16'(COLS - 1);
      HBLANK:  last_cnt = 16'(HB_LEN - 1);
      VBLANK:  last_cnt = 16'(VB_LEN - 1);
      default: last_cnt = '0;
    endcase
  end

  // Frame sequencer: leaves IDLE immediately, otherwise advances on ticks only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    if (state_q == IDLE) begin
      if (leave_idle) begin
        state_d = FSYNC;
        cnt_d   = '0;
        row_d   = '0;
      end
    end else if (tick) begin
      if (cnt_q == last_cnt) begin
        cnt_d = '0;
        case (state_q)
          FSYNC:  state_d = LSYNC;
          LSYNC:  state_d = PIXELS;
          PIXELS: state_d = HBLANK;
          HBLANK: begin
            if (row_q < 16'(ROWS - 1)) begin
              state_d = LSYNC;
              row_d   = row_q + 16'd1;
            end else begin
              state_d = VBLANK;
            end
          end
          VBLANK: begin
            state_d = (enable && cont_mode) ? FSYNC : IDLE;
            row_d   = '0;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Marker pushed on every PIXELS tick, tagged with packet framing.
  always_comb begin
    push_s        = '0;
    push_s.valid  = (state_q == PIXELS);
    push_s.mk.sop = (row_q == 16'd0) && (cnt_q == 16'd0);
    push_s.mk.eop = (row_q == 16'(ROWS - 1)) && (cnt_q == 16'(COLS - 1));
  end

  generate
    if (SAMPLE_DLY == 0) begin : g_no_dly
      assign emerge_s  = push_s;
      assign pipe_busy = 1'b0;
    end else begin : g_dly
      slot_t pipe_q [SAMPLE_DLY];
      slot_t pipe_d [SAMPLE_DLY];
      for (genvar gi = 0; gi < SAMPLE_DLY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign pipe_d[gi] = tick ? push_s : pipe_q[gi];
        end else begin : g_body
          assign pipe_d[gi] = tick ? pipe_q[gi-1] : pipe_q[gi];
        end
        // One delay-line slot, advancing once per pixel tick.
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
          if (!reset_reset_n) pipe_q[gi] <= '0;
          else                pipe_q[gi] <= pipe_d[gi];
        end
      end
      assign emerge_s = pipe_q[SAMPLE_DLY-1];
      // Any occupied slot keeps the sampler alive.
      always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < SAMPLE_DLY; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
      end
    end
  endgenerate

  assign cap  = tick && emerge_s.valid;
  assign drop = cap && fifo_full && !st.out_ready;

`ifdef IR_READOUT_TESTPAT_EN
  logic [15:0]       pat_row_q, pat_row_d, pat_col_q, pat_col_d, base_row, base_col;
  logic [DATA_W-1:0] pat_val;

  // Coordinate tracker following the pixels as they leave the delay line.
  always_comb begin
    base_row  = emerge_s.mk.sop ? 16'd0 : pat_row_q;
    base_col  = emerge_s.mk.sop ? 16'd0 : pat_col_q;
    pat_val   = DATA_W'(base_row + base_col);
    pat_row_d = pat_row_q;
    pat_col_d = pat_col_q;
    if (cap) begin
      if (base_col == 16'(COLS - 1)) begin
        pat_col_d = '0;
        pat_row_d = base_row + 16'd1;
      end else begin
        pat_col_d = base_col + 16'd1;
        pat_row_d = base_row;
      end
    end
  end

  // Test-pattern coordinate registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pat_row_q <= '0;
      pat_col_q <= '0;
    end else begin
      pat_row_q <= pat_row_d;
      pat_col_q <= pat_col_d;
    end
  end

  assign cap_data = testpat ? pat_val : datain;
`else
  assign cap_data = datain;
`endif

  ir_readout_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (cap),
    .wr_data ({emerge_s.mk.eop, emerge_s.mk.sop, cap_data}),
    .rd_en   (st.out_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign st.out_data  = fifo_rd[DATA_W-1:0];
  assign st.out_sop   = fifo_rd[DATA_W];
  assign st.out_eop   = fifo_rd[DATA_W+1];
  assign st.out_valid = !fifo_empty;

  // Drop statistics (cleared on enable rising) and completed-frame counter.
  always_comb begin
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (enable && !enable_q) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (cap && emerge_s.mk.eop) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // State, divider, registered syncs and status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      fsync_q     <= 1'b0;
      lsync_q     <= 1'b0;
      psync_q     <= 1'b0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      fsync_q     <= (state_d == FSYNC);
      lsync_q     <= (state_d == LSYNC);
      psync_q     <= (state_d == PIXELS);
      enable_q    <= enable;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fsync     = fsync_q;
  assign lsync     = lsync_q;
  assign psync     = psync_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ir_sensor_readout.sv
// tb_ir_sensor_readout: directed bench for ir_sensor_readout with a small
// geometry (4x2 pixels, 48-tick frame = 192 clocks, 4-entry FIFO).
module tb_ir_sensor_readout;
  localparam int DW     = 8;
  localparam int PERIOD = 192;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          cont_mode = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] datain = '0;
`ifdef IR_READOUT_TESTPAT_EN
  logic          testpat = 1'b0;
`endif
  logic          sensor_clk, fsync, lsync, psync, busy, overflow;
  logic [15:0]   drop_cnt, frame_cnt;

  ir_sensor_readout_if #(.DATA_W(DW)) st_if ();

  ir_sensor_readout #(
    .DATA_W(DW), .COLS(4), .ROWS(2), .CLK_DIV(4), .SAMPLE_DLY(2),
    .FS_LEN(4), .LS_LEN(2), .HB_LEN(8), .VB_LEN(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .cont_mode     (cont_mode),
    .start         (start),
    .datain        (datain),
`ifdef IR_READOUT_TESTPAT_EN
    .testpat       (testpat),
`endif
    .sensor_clk    (sensor_clk),
    .fsync         (fsync),
    .lsync         (lsync),
    .psync         (psync),
    .busy          (busy),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .frame_cnt     (frame_cnt),
    .st            (st_if.master)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t beats[$];
  int    fs_times[$];
  int    cyc = 0;
  logic  fsync_prev = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Stream and fsync monitor, sampled mid-cycle.
  always @(negedge clk_clk) begin
    beat_t b;
    if (st_if.out_valid && st_if.out_ready) begin
      b.data = st_if.out_data;
      b.sop  = st_if.out_sop;
      b.eop  = st_if.out_eop;
      beats.push_back(b);
      $display("beat %0d data=%0d sop=%0b eop=%0b", beats.size(), b.data, b.sop, b.eop);
    end
    if (fsync && !fsync_prev) fs_times.push_back(cyc);
    fsync_prev <= fsync;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic logic [31:0] sop_mask();
    logic [31:0] m;
    m = '0;
    foreach (beats[i]) if (i < 32) m[i] = beats[i].sop;
    return m;
  endfunction

  function automatic logic [31:0] eop_mask();
    logic [31:0] m;
    m = '0;
    foreach (beats[i]) if (i < 32) m[i] = beats[i].eop;
    return m;
  endfunction

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Start pulse sampled on the next edge; called just after an edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_clk);
    #1;
    start = 1'b0;
  endtask

  // Drive datain with the pixel-tick index counted from the start edge.
  task automatic run_data(input int n);
    for (int c = 1; c <= n; c++) begin
      datain = DW'((c - 1) / 4);
      @(posedge clk_clk);
      #1;
    end
  endtask

  int exp_t1 [8] = '{8, 9, 10, 11, 22, 23, 24, 25};

  initial begin
    st_if.out_ready = 1'b1;
    tick_clk(3);
    check("rst_flags", {sensor_clk, fsync, lsync, psync, busy, overflow,
                        st_if.out_valid, st_if.out_sop, st_if.out_eop}, 0);
    check("rst_data", st_if.out_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    #2 reset_reset_n = 1'b1;
    tick_clk(2);
    enable = 1'b1;
    tick_clk(2);

    // Single frame, always ready.
    beats.delete();
    pulse_start();
    run_data(200);
    check("t1_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < beats.size()) check($sformatf("t1_data%0d", i), beats[i].data, exp_t1[i]);
    check("t1_sop", sop_mask(), 32'h01);
    check("t1_eop", eop_mask(), 32'h80);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_busy", busy, 0);

    // Continuous mode for three frames.
    beats.delete();
    fs_times.delete();
    cont_mode = 1'b1;
    tick_clk(2 * PERIOD + 50);
    cont_mode = 1'b0;
    tick_clk(220);
    check("t2_fsync_edges", fs_times.size(), 3);
    if (fs_times.size() >= 3) begin
      check("t2_spacing1", fs_times[1] - fs_times[0], PERIOD);
      check("t2_spacing2", fs_times[2] - fs_times[1], PERIOD);
    end
    check("t2_frame_cnt", frame_cnt, 4);
    check("t2_beats", beats.size(), 24);
    check("t2_busy", busy, 0);

    // Sink stalled for a whole frame.
    st_if.out_ready = 1'b0;
    beats.delete();
    pulse_start();
    run_data(200);
    check("t3_overflow", overflow, 1);
    check("t3_drop_cnt", drop_cnt, 4);
    check("t3_valid", st_if.out_valid, 1);
    check("t3_frame_cnt", frame_cnt, 5);
    st_if.out_ready = 1'b1;
    tick_clk(10);
    check("t3_beats", beats.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < beats.size()) check($sformatf("t3_data%0d", i), beats[i].data, exp_t1[i]);
    check("t3_sop", sop_mask(), 32'h1);
    check("t3_eop", eop_mask(), 32'h0);
    enable = 1'b0;
    tick_clk(2);
    enable = 1'b1;
    tick_clk(2);
    check("t3_ovf_clear", overflow, 0);
    check("t3_drop_clear", drop_cnt, 0);

    // Enable dropped during row 0.
    beats.delete();
    pulse_start();
    run_data(40);
    enable = 1'b0;
    tick_clk(170);
    check("t4_beats", beats.size(), 8);
    check("t4_sop", sop_mask(), 32'h01);
    check("t4_eop", eop_mask(), 32'h80);
    check("t4_frame_cnt", frame_cnt, 6);
    check("t4_busy", busy, 0);
    pulse_start();
    tick_clk(20);
    check("t4_start_ignored", busy, 0);
    check("t4_no_beats", beats.size(), 8);
    enable = 1'b1;
    tick_clk(2);

    // Reset in the middle of PIXELS.
    st_if.out_ready = 1'b0;
    beats.delete();
    pulse_start();
    run_data(38);
    check("t5_pre_psync", psync, 1);
    check("t5_pre_valid", st_if.out_valid, 1);
    #2 reset_reset_n = 1'b0;
    #1;
    check("t5_async_flags", {sensor_clk, fsync, lsync, psync, busy, overflow,
                             st_if.out_valid, st_if.out_sop, st_if.out_eop}, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    tick_clk(2);
    #2 reset_reset_n = 1'b1;
    tick_clk(2);
    st_if.out_ready = 1'b1;
    beats.delete();
    pulse_start();
    run_data(200);
    check("t5_beats", beats.size(), 8);
    if (beats.size() > 0) check("t5_first_data", beats[0].data, 8);
    check("t5_sop", sop_mask(), 32'h01);
    check("t5_eop", eop_mask(), 32'h80);
    check("t5_frame_cnt", frame_cnt, 1);

`ifdef IR_READOUT_TESTPAT_EN
    // Test pattern: row 1 reads 1,2,3,4.
    testpat = 1'b1;
    beats.delete();
    pulse_start();
    run_data(200);
    check("t6_beats", beats.size(), 8);
    for (int i = 4; i < 8; i++)
      if (i < beats.size()) check($sformatf("t6_data%0d", i), beats[i].data, i - 3);
    testpat = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ir_sensor_readout.md
# ir_sensor_readout

Parametrised readout engine for the infrared focal-plane sensors on the FPGA fabric, succeeding the fixed LWIR/SWIR sensor ports of the SoC. It generates the sensor pixel clock and the frame, line and pixel sync strobes for a programmable geometry. It captures `DATA_W`-bit pixel data after a configurable sensor pipeline delay and streams it through an internal FIFO as Avalon-ST packets, one packet per frame, towards the HPS frame-buffer DMA.

## Interface
- `DATA_W`, 8: pixel width on `datain` and `out_data`.
- `COLS`, 320: pixels per line.
- `ROWS`, 256: lines per frame.
- `CLK_DIV`, 4: system clocks per pixel tick; even, ≥2.
- `SAMPLE_DLY`, 2: pixel ticks from pixel-sync to valid `datain`; 0..7.
- `FS_LEN`, `LS_LEN`, `HB_LEN`, `VB_LEN`, 4/2/8/16: fsync, lsync, h-blank and v-blank lengths in ticks; each ≥1.
- `FIFO_DEPTH`, 16: output FIFO entries; power of two.
- `clk_clk` in 1: system clock.
- `reset_reset_n` in 1: asynchronous active-low reset.
- `enable` in 1: level; run while high.
- `cont_mode` in 1: 1 = free-running frames, 0 = one frame per `start`.
- `start` in 1: one-cycle pulse; starts one frame when `cont_mode`=0.
- `datain` in DATA_W: sensor pixel bus.
- `sensor_clk` out 1: pixel clock, 50 % duty.
- `fsync` / `lsync` / `psync` out 1: frame, line and pixel strobes.
- `out_data` out DATA_W, `out_valid` out 1, `out_ready` in 1, `out_sop` out 1, `out_eop` out 1: Avalon-ST source.
- `busy` out 1: high from leaving IDLE until returning to IDLE.
- `overflow` out 1: sticky; cleared by a rising edge of `enable`.
- `drop_cnt` out 16: dropped pixels, saturating; cleared with `overflow`.
- `frame_cnt` out 16: completed frames, wraps.

## Operation
- Divider counter `div` runs 0..CLK_DIV-1 while not IDLE. A tick occurs at `div`=CLK_DIV-1. `sensor_clk` is high when `div` < CLK_DIV/2.
- FSM advances on ticks only, apart from leaving IDLE:
  - IDLE → FSYNC when `enable` and (`cont_mode` or `start`).
  - FSYNC (FS_LEN) → LSYNC (LS_LEN) → PIXELS (COLS) → HBLANK (HB_LEN).
  - HBLANK → LSYNC if the row counter < ROWS-1, else → VBLANK (VB_LEN).
  - VBLANK → FSYNC if `enable` and `cont_mode`, else → IDLE.
- `fsync`/`lsync` are high for the whole FSYNC/LSYNC states. `psync` is high for the whole PIXELS state.
- Each PIXELS tick pushes a marker into a SAMPLE_DLY-deep tick shift register. The marker carries sop (first pixel of row 0) and eop (last pixel of row ROWS-1). `datain` is registered on the tick at which a marker emerges. With SAMPLE_DLY=0, it is registered on the PIXELS tick itself.
- The sampler keeps running through blanking and IDLE until every in-flight marker has been captured.
- Captured pixel and its flags are written to the FIFO. If the FIFO is full, the pixel is dropped: `overflow` sets and `drop_cnt` increments. The sop/eop flags of a dropped pixel are lost.
- `frame_cnt` increments on the tick the eop marker is sampled, whether or not that pixel is dropped.
- `enable` falling mid-frame: the current frame completes, then the FSM returns to IDLE. `start` pulses while busy are ignored.

## Timing
- Every output resets to 0 (`out_*`, syncs, `sensor_clk`, counters, flags). Reset also flushes the FIFO and marker pipeline and forces IDLE. Mid-frame reset aborts without emitting eop.
- Syncs change only in the system-clock cycle after a tick (registered).
- FIFO is show-ahead. `out_valid` rises 1 clock after the write. A transfer happens when `out_valid` && `out_ready`.
- Simultaneous FIFO read and write when full: the write succeeds.
- Frame period in ticks: FS_LEN + ROWS·(LS_LEN+COLS+HB_LEN) + VB_LEN.

## Configuration
- `IR_READOUT_TESTPAT_EN` defined: an extra input `testpat` (1 bit) selects a pattern instead of `datain`. The pattern is (row + col) mod 2^DATA_W.
- Not defined: there is no `testpat` port, and `datain` is always captured.

## Structure
- Package `ir_readout_pkg` holds:
  - the FSM state enum {IDLE, FSYNC, LSYNC, PIXELS, HBLANK, VBLANK};
  - the marker struct {sop, eop};
  - constant `MAX_SAMPLE_DLY` = 7.
- Sub-module `ir_readout_fifo`: synchronous show-ahead FIFO carrying {eop, sop, data}, with full/empty outputs.

## Test plan
- COLS=4, ROWS=2, CLK_DIV=4, SAMPLE_DLY=2, `cont_mode`=0, one `start`, `datain`=tick index, `out_ready`=1 → exactly 8 beats. sop on beat 1 and eop on beat 8. `frame_cnt`=1, `busy` low afterwards.
- Same geometry, `cont_mode`=1 for 3 frames → FSYNC edges spaced by the frame period in ticks × CLK_DIV clocks. `frame_cnt`=3.
- `out_ready`=0 for one full frame, FIFO_DEPTH=4 → 4 beats retained. `overflow`=1, `drop_cnt`=4, and the eop pixel is lost.
- `enable` dropped during row 0 → frame finishes with eop, then IDLE. A following `start` while `enable`=0 is ignored.
- Reset asserted mid-PIXELS → all outputs 0 asynchronously, `out_valid`=0. After release, `start` produces a clean frame beginning with sop.
- With `IR_READOUT_TESTPAT_EN` and `testpat`=1, DATA_W=8 → row 1 beats read 1,2,3,4.
